// File: rtl/sram_pkg.sv
// Shared constants, march state encoding and the March C- element table
// for the sram_bist engine.
package sram_pkg;

    localparam int SRAM_ADDR_W = 6;
    localparam int SRAM_DATA_W = 8;
    localparam int SRAM_DEPTH  = 1 << SRAM_ADDR_W;
    localparam int FAIL_CNT_W  = 8;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_M0    = 4'd1,
        ST_M1    = 4'd2,
        ST_M2    = 4'd3,
        ST_M3    = 4'd4,
        ST_M4    = 4'd5,
        ST_M5    = 4'd6,
        ST_DRAIN = 4'd7,
        ST_DONE  = 4'd8
    } march_state_t;

    // Element table, bit i describes element Mi. Bits 6 and 7 are zero so
    // that any non-march state maps onto "no operation".
    localparam logic [7:0] EL_DOWN   = 8'b0011_1000;  // M3..M5 walk 63 -> 0
    localparam logic [7:0] EL_HAS_RD = 8'b0011_1110;  // M1..M5 start with a read
    localparam logic [7:0] EL_RD_INV = 8'b0001_0100;  // M2, M4 expect ~BG
    localparam logic [7:0] EL_HAS_WR = 8'b0001_1111;  // M0..M4 end with a write
    localparam logic [7:0] EL_WR_INV = 8'b0000_1010;  // M1, M3 write ~BG

    // Element index of a state; IDLE wraps to 7 and DRAIN/DONE land on 6/7.
    function automatic logic [2:0] elem_idx(march_state_t s);
        return 3'(s) - 3'd1;
    endfunction

    function automatic logic is_march(march_state_t s);
        return (s >= ST_M0) && (s <= ST_M5);
    endfunction

    function automatic logic elem_down(march_state_t s);
        return EL_DOWN[elem_idx(s)];
    endfunction

    function automatic logic elem_has_rd(march_state_t s);
        return EL_HAS_RD[elem_idx(s)];
    endfunction

    function automatic logic elem_rd_inv(march_state_t s);
        return EL_RD_INV[elem_idx(s)];
    endfunction

    function automatic logic elem_has_wr(march_state_t s);
        return EL_HAS_WR[elem_idx(s)];
    endfunction

    function automatic logic elem_wr_inv(march_state_t s);
        return EL_WR_INV[elem_idx(s)];
    endfunction

endpackage

// File: rtl/sram_bist_log.sv
// Read-compare pipeline and result logging for sram_bist: delays each read
// by one cycle to meet the SRAM data, counts mismatches (saturating),
// captures the first failure and produces the pass flag.
module sram_bist_log
    import sram_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  finish,
    input  logic                  rd_issue,
    input  logic [ADDR_W-1:0]     rd_addr,
    input  logic [DATA_W-1:0]     rd_exp,
    input  logic [DATA_W-1:0]     rd_data,
    output logic                  pass,
    output logic [FAIL_CNT_W-1:0] fail_count,
    output logic [ADDR_W-1:0]     first_fail_addr,
    output logic [DATA_W-1:0]     first_fail_exp,
    output logic [DATA_W-1:0]     first_fail_act
);

    logic              chk_q;
    logic [DATA_W-1:0] exp_q;
    logic [ADDR_W-1:0] addr_q;
    logic              miss;

    assign miss = chk_q && (rd_data != exp_q);

    // Register read context, then log the compare one cycle later.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chk_q           <= 1'b0;
            exp_q           <= '0;
            addr_q          <= '0;
            pass            <= 1'b0;
            fail_count      <= '0;
            first_fail_addr <= '0;
            first_fail_exp  <= '0;
            first_fail_act  <= '0;
        end else begin
            chk_q <= rd_issue;
            if (rd_issue) begin
                exp_q  <= rd_exp;
                addr_q <= rd_addr;
            end
            if (clear) begin
                pass            <= 1'b0;
                fail_count      <= '0;
                first_fail_addr <= '0;
                first_fail_exp  <= '0;
                first_fail_act  <= '0;
            end else begin
                if (miss) begin
                    if (fail_count != '1) begin
                        fail_count <= fail_count + 1'b1;
                    end
                    if (fail_count == '0) begin
                        first_fail_addr <= addr_q;
                        first_fail_exp  <= exp_q;
                        first_fail_act  <= rd_data;
                    end
                end
                // The last read is compared during DRAIN, so include it here.
                if (finish) begin
                    pass <= (fail_count == '0) && !miss;
                end
            end
        end
    end

endmodule

// File: rtl/sram_bist.sv
// March C- BIST engine driving a 64x8 SRAM port. The FSM walks the six
// march elements, registers every SRAM pin, and hands reads to
// sram_bist_log for checking.
module sram_bist
    import sram_pkg::*;
#(
    parameter int                ADDR_W = SRAM_ADDR_W,
    parameter int                DATA_W = SRAM_DATA_W,
    parameter logic [DATA_W-1:0] BG     = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [FAIL_CNT_W-1:0] fail_count,
    output logic [ADDR_W-1:0]     first_fail_addr,
    output logic [DATA_W-1:0]     first_fail_exp,
    output logic [DATA_W-1:0]     first_fail_act,
    output logic                  mem_enable,
    output logic                  mem_rw,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W-1:0]     mem_data_in,
    input  logic [DATA_W-1:0]     mem_data_out
);

    localparam logic [ADDR_W-1:0] ADDR_FIRST = '0;
    localparam logic [ADDR_W-1:0] ADDR_LAST  = '1;

    march_state_t      state, nxt_state;
    logic [ADDR_W-1:0] addr, nxt_addr;
    logic              rd_ph, nxt_rd;       // current op is the read half
    logic [DATA_W-1:0] rd_exp;              // expected data of the current read
    logic              nxt_march;

    // Next op: read->write within an address, then step address, then element.
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        nxt_state = state;
        nxt_addr  = addr;
        nxt_rd    = rd_ph;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    nxt_state = ST_M0;
                    nxt_addr  = elem_down(ST_M0) ? ADDR_LAST : ADDR_FIRST;
                    nxt_rd    = elem_has_rd(ST_M0);
                end
            end
            ST_DRAIN: nxt_state = ST_DONE;
            ST_DONE:  nxt_state = ST_IDLE;
            default: begin
                if (rd_ph && elem_has_wr(state)) begin
                    nxt_rd = 1'b0;
                end else if (addr == (elem_down(state) ? ADDR_FIRST : ADDR_LAST)) begin
                    // M5 + 1 is DRAIN, which the table treats as "no op".
                    nxt_state = march_state_t'(state + 4'd1);
                    nxt_addr  = elem_down(nxt_state) ? ADDR_LAST : ADDR_FIRST;
                    nxt_rd    = elem_has_rd(nxt_state);
                end else begin
                    nxt_addr = elem_down(state) ? addr - 1'b1 : addr + 1'b1;
                    nxt_rd   = elem_has_rd(state);
                end
            end
        endcase
        nxt_march = is_march(nxt_state);
    end

    // FSM state and registered SRAM/handshake outputs for the next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            addr        <= '0;
            rd_ph       <= 1'b0;
            rd_exp      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_enable  <= 1'b0;
            mem_rw      <= 1'b0;
            mem_address <= '0;
            mem_data_in <= '0;
        end else begin
            state       <= nxt_state;
            addr        <= nxt_addr;
            rd_ph       <= nxt_rd;
            rd_exp      <= elem_rd_inv(nxt_state) ? ~BG : BG;
            busy        <= nxt_march || (nxt_state == ST_DRAIN);
            done        <= (nxt_state == ST_DONE);
            mem_enable  <= nxt_march;
            mem_rw      <= nxt_march && nxt_rd;
            mem_address <= nxt_march ? nxt_addr : '0;
            mem_data_in <= (nxt_march && !nxt_rd) ?
                           (elem_wr_inv(nxt_state) ? ~BG : BG) : '0;
        end
    end

    sram_bist_log #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_log (
        .clk             (clk),
        .reset           (reset),
        .clear           ((state == ST_IDLE) && start),
        .finish          (state == ST_DRAIN),
        .rd_issue        (mem_enable && mem_rw),
        .rd_addr         (mem_address),
        .rd_exp          (rd_exp),
        .rd_data         (mem_data_out),
        .pass            (pass),
        .fail_count      (fail_count),
        .first_fail_addr (first_fail_addr),
        .first_fail_exp  (first_fail_exp),
        .first_fail_act  (first_fail_act)
    );

endmodule

// File: tb/tb_sram_bist.sv
// Scoreboard bench for sram_bist: a behavioural 64x8 SRAM with a fault shim,
// a second instance with BG=8'h55 reading all-ones, and a monitor that pops
// expected op records and run results as the DUTs present them.
module tb_sram_bist;
    import sram_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, start_b, fault_on;

    logic       busy, done, pass;
    logic [7:0] fail_count, first_fail_exp, first_fail_act;
    logic [5:0] first_fail_addr, mem_address;
    logic       mem_enable, mem_rw;
    logic [7:0] mem_data_in, mem_data_out;

    logic       busy_b, done_b, pass_b;
    logic [7:0] fail_count_b, first_fail_exp_b, first_fail_act_b;
    logic [5:0] first_fail_addr_b, mem_address_b;
    logic       mem_enable_b, mem_rw_b;
    logic [7:0] mem_data_in_b, mem_data_out_b;

    assign mem_data_out_b = 8'hFF;

    sram_bist dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .pass(pass), .fail_count(fail_count), .first_fail_addr(first_fail_addr),
        .first_fail_exp(first_fail_exp), .first_fail_act(first_fail_act),
        .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_address(mem_address),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    sram_bist #(.BG(8'h55)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .fail_count(fail_count_b), .first_fail_addr(first_fail_addr_b),
        .first_fail_exp(first_fail_exp_b), .first_fail_act(first_fail_act_b),
        .mem_enable(mem_enable_b), .mem_rw(mem_rw_b), .mem_address(mem_address_b),
        .mem_data_in(mem_data_in_b), .mem_data_out(mem_data_out_b)
    );

    // Behavioural SRAM: write at the edge, read data registered for next cycle.
    logic [7:0] sram [SRAM_DEPTH];
    logic [7:0] rd_q = 8'h00;
    logic [5:0] rd_addr_q = 6'd0;
    always @(posedge clk) begin
        if (mem_enable) begin
            if (mem_rw) begin
                rd_q      <= sram[mem_address];
                rd_addr_q <= mem_address;
            end else begin
                sram[mem_address] <= mem_data_in;
            end
        end
    end
    // Fault shim: bit 3 stuck at 1 on reads from address 5.
    assign mem_data_out = rd_q | ((fault_on && rd_addr_q == 6'd5) ? 8'h08 : 8'h00);

    typedef struct {
        int         cyc;
        logic       en;
        logic       rw;
        logic [5:0] addr;
        logic [7:0] data;
        logic       chk_data;
    } op_t;

    typedef struct {
        int         inst;
        logic       pass;
        logic [7:0] cnt;
        logic [5:0] faddr;
        logic [7:0] fexp;
        logic [7:0] fact;
    } res_t;

    op_t  op_q[$];
    res_t res_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int base = 0;
    int busy_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic push_op(input int c, input logic en, input logic rw,
                           input logic [5:0] a, input logic [7:0] d, input logic cd);
        op_t o;
        o.cyc = c; o.en = en; o.rw = rw; o.addr = a; o.data = d; o.chk_data = cd;
        op_q.push_back(o);
    endtask

    task automatic push_res(input int inst, input logic p, input logic [7:0] cnt,
                            input logic [5:0] fa, input logic [7:0] fe, input logic [7:0] fx);
        res_t r;
        r.inst = inst; r.pass = p; r.cnt = cnt; r.faddr = fa; r.fexp = fe; r.fact = fx;
        res_q.push_back(r);
    endtask

    // Pulse start so that the next rising edge is E0; cycle n is then cyc-base.
    task automatic start_run(input int inst);
        @(negedge clk);
        if (inst == 0) start = 1'b1;
        else           start_b = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        start_b = 1'b0;
        base    = cyc - 1;
    endtask

    // Return at the falling edge inside cycle 'target' of the current run.
    task automatic wait_until(input int target);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while ((cyc - base) < target && guard < 2000);
    endtask

    task automatic wait_results();
        int guard;
        guard = 0;
        while (res_q.size() != 0 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (res_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: %0d result(s) still pending, required 0", res_q.size());
            res_q.delete();
        end
        repeat (8) @(negedge clk);
    endtask

    // Monitor: compare scheduled ops and pop a result on every done pulse.
    always @(negedge clk) begin : monitor
        op_t  o;
        res_t r;
        int   n;
        n = cyc - base;
        if (n == 1) busy_cnt = 0;
        if (busy || busy_b) busy_cnt++;
        if (op_q.size() != 0 && op_q[0].cyc == n) begin
            o = op_q.pop_front();
            check($sformatf("op%0d_enable", n), mem_enable, o.en);
            check($sformatf("op%0d_rw", n), mem_rw, o.rw);
            check($sformatf("op%0d_addr", n), mem_address, o.addr);
            if (o.chk_data) check($sformatf("op%0d_data_in", n), mem_data_in, o.data);
        end
        if (done || done_b) begin
            if (res_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: done pulse at cycle %0d, required none", n);
            end else begin
                r = res_q.pop_front();
                check("done_cycle", n, 642);
                check("busy_cycles", busy_cnt, 641);
                check("done_source", done_b, (r.inst == 1));
                if (r.inst == 0) begin
                    check("pass", pass, r.pass);
                    check("fail_count", fail_count, r.cnt);
                    check("first_fail_addr", first_fail_addr, r.faddr);
                    check("first_fail_exp", first_fail_exp, r.fexp);
                    check("first_fail_act", first_fail_act, r.fact);
                end else begin
                    check("bg55_pass", pass_b, r.pass);
                    check("bg55_fail_count", fail_count_b, r.cnt);
                    check("bg55_first_fail_addr", first_fail_addr_b, r.faddr);
                    check("bg55_first_fail_exp", first_fail_exp_b, r.fexp);
                    check("bg55_first_fail_act", first_fail_act_b, r.fact);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        start_b  = 1'b0;
        fault_on = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_fail_count", fail_count, 0);
        check("rst_mem_enable", mem_enable, 0);
        check("rst_mem_rw", mem_rw, 0);
        check("rst_mem_address", mem_address, 0);
        check("rst_mem_data_in", mem_data_in, 0);
        check("rst_first_fail_addr", first_fail_addr, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Clean run with an address/op trace.
        start_run(0);
        push_res(0, 1'b1, 8'd0, 6'd0, 8'h00, 8'h00);
        push_op(1,   1'b1, 1'b0, 6'd0,  8'h00, 1'b1);
        push_op(2,   1'b1, 1'b0, 6'd1,  8'h00, 1'b1);
        push_op(64,  1'b1, 1'b0, 6'd63, 8'h00, 1'b1);
        push_op(65,  1'b1, 1'b1, 6'd0,  8'h00, 1'b0);
        push_op(66,  1'b1, 1'b0, 6'd0,  8'hFF, 1'b1);
        push_op(193, 1'b1, 1'b1, 6'd0,  8'h00, 1'b0);
        push_op(194, 1'b1, 1'b0, 6'd0,  8'h00, 1'b1);
        push_op(321, 1'b1, 1'b1, 6'd63, 8'h00, 1'b0);
        push_op(322, 1'b1, 1'b0, 6'd63, 8'hFF, 1'b1);
        push_op(577, 1'b1, 1'b1, 6'd63, 8'h00, 1'b0);
        push_op(640, 1'b1, 1'b1, 6'd0,  8'h00, 1'b0);
        push_op(641, 1'b0, 1'b0, 6'd0,  8'h00, 1'b1);
        wait_results();
        check("ops_consumed", op_q.size(), 0);

        // start re-asserted mid-run and during DRAIN must be ignored.
        start_run(0);
        push_res(0, 1'b1, 8'd0, 6'd0, 8'h00, 8'h00);
        wait_until(10);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_until(641);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_results();

        // Stuck-at-1 on bit 3 of address 5: M1, M3, M5 reads of 8'h00 fail.
        fault_on = 1'b1;
        start_run(0);
        push_res(0, 1'b0, 8'd3, 6'd5, 8'h00, 8'h08);
        wait_until(1);
        check("pass_cleared_at_start", pass, 0);
        wait_results();
        fault_on = 1'b0;

        // Results cleared at start, then reset aborts the run in cycle 300.
        start_run(0);
        wait_until(1);
        check("fail_count_cleared", fail_count, 0);
        check("first_fail_addr_cleared", first_fail_addr, 0);
        check("first_fail_act_cleared", first_fail_act, 0);
        wait_until(300);
        #2;
        reset = 1'b1;
        #1;
        check("abort_mem_enable", mem_enable, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_stays_idle", busy, 0);

        // Fresh run after the abort completes normally.
        start_run(0);
        push_res(0, 1'b1, 8'd0, 6'd0, 8'h00, 8'h00);
        wait_results();

        // BG=8'h55 instance reading all-ones everywhere: 320 mismatches.
        start_run(1);
        push_res(1, 1'b0, 8'd255, 6'd0, 8'h55, 8'hFF);
        wait_results();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_bist.md
Name: sram_bist

Overview:
- Built-in self-test engine that sits directly upstream of the 64x8 SRAM macro (sram_512) and drives its enable/rw/address/data_in pins.
- Runs a March C- sequence over all 64 words and checks every read against the expected background.
- Reports pass/fail, a saturating mismatch count, and details of the first failure.
- Owns the SRAM port while busy; the system mux selects it via busy.

Parameters:
- ADDR_W, 6, SRAM address width; depth = 2^ADDR_W = 64.
- DATA_W, 8, SRAM word width.
- BG, 8'h00, background pattern; its complement ~BG is the second pattern.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin test; sampled in IDLE only.
- busy  out  1  high while march ops or drain are in progress.
- done  out  1  one-cycle pulse when results become valid.
- pass  out  1  high when the last run had zero mismatches; held until the next start.
- fail_count  out  8  mismatch count, saturates at 255.
- first_fail_addr  out  ADDR_W  address of the first mismatch.
- first_fail_exp  out  DATA_W  expected data at the first mismatch.
- first_fail_act  out  DATA_W  actual data at the first mismatch.
- mem_enable  out  1  to SRAM enable.
- mem_rw  out  1  to SRAM rw; 1 = read, 0 = write.
- mem_address  out  ADDR_W  to SRAM address.
- mem_data_in  out  DATA_W  to SRAM data_in.
- mem_data_out  in  DATA_W  from SRAM data_out; valid 1 cycle after a read is issued.

Behaviour:
- Reset (async, active-high): state=IDLE; all outputs 0, including mem_* and the result registers.
- SRAM timing:
  - Write takes effect at the clock edge ending the cycle in which mem_enable=1 and mem_rw=0.
  - Read data appears on mem_data_out in the cycle after the issue cycle.
- March elements (U = address 0→63, D = address 63→0):
  - M0 U w(BG)
  - M1 U r(BG) w(~BG)
  - M2 U r(~BG) w(BG)
  - M3 D r(BG) w(~BG)
  - M4 D r(~BG) w(BG)
  - M5 D r(BG)
- Per address, read and write are issued in consecutive cycles: read first, then write.
- Total: 640 op cycles.
- States: IDLE → M0..M5 → DRAIN → DONE → IDLE.
  - Sub-phase bit RD/WR is used in M1–M4.
  - An element advances after its last op at the end address.
- Timing, with E0 = the edge at which start=1 is sampled in IDLE:
  - Op n is driven in cycle n (n = 1..640), with mem_enable=1.
  - Cycle 641 is DRAIN: mem_enable=0; the final read is compared.
  - Cycle 642 is DONE: done=1, pass valid, busy=0.
  - busy is high in cycles 1..641.
  - Next cycle returns to IDLE.
- Compare pipeline:
  - On a read-issue edge, register chk_q=1, exp_q and addr_q.
  - In the following cycle, compare exp_q with mem_data_out when chk_q=1.
  - Log the result at the end of that cycle.
- Logging:
  - Any mismatch increments fail_count, saturating at 255.
  - On the first mismatch of a run (fail_count==0), capture addr, exp and act.
  - pass <= (fail_count==0 and no mismatch in the drain cycle); registered entering DONE.
- On start:
  - fail_count, first_fail_* and pass are cleared at E0.
  - Results are otherwise held until the next start.
- start is ignored while not in IDLE, including during DRAIN and DONE.
- mem_data_in = 0 and mem_rw = 0 whenever mem_enable = 0.
- Reset mid-run aborts immediately: outputs go to 0 and no done pulse is produced.
- A start after that runs the full sequence from M0.

Decomposition:
- Package sram_pkg holds:
  - constants SRAM_ADDR_W=6, SRAM_DATA_W=8, SRAM_DEPTH=64;
  - march-state encoding (IDLE, M0–M5, DRAIN, DONE);
  - the direction/op-table localparams (element → direction, read polarity, write polarity, has_write).
- One sub-module, sram_bist_log, contains:
  - the compare pipeline registers (chk_q, exp_q, addr_q);
  - the saturating counter;
  - first-fail capture and pass generation.
- The FSM and address counter stay in sram_bist.

Test Plan:
- With sram_512 attached, after reset pulse start at E0 → busy cycles 1..641, done pulse at cycle 642, pass=1, fail_count=0.
- Bit 3 of mem_data_out at address 5 forced to 1 (shim between SRAM and BIST), start → fail_count=3 (M1, M3, M5 reads), first_fail_addr=5, first_fail_exp=8'h00, first_fail_act=8'h08, pass=0.
- Address monitor → M0 first op address 0 w 8'h00; M3 first op is a read at address 63; last op at cycle 640 is r(8'h00) at address 0.
- start re-asserted in cycles 10 and 641 → ignored; single done pulse at cycle 642.
- reset asserted at cycle 300 → mem_enable, busy and done go to 0 within the same cycle; a new start yields pass=1 at 642 cycles.
- BG=8'h55 instance, all addresses returning 8'hFF on a read (fault shim) → fail_count=255 (saturated; 320 mismatches total), first_fail_addr=0, first_fail_exp=8'h55.
